pixel_array_sequencer: RTL
==========================

// Module: pixel_array_sequencer
// PURPOSE
//  Frame controller for the digital pixel sensor array. Runs one full frame per trigger:
//  erase -> expose -> convert (ramp + shared counter) -> row-by-row readout.
//  Replaces hand-sequenced EXPOSE/CONVERT/WRITE_ENABLE/READ stimulus with a parametrised FSM.
//  Adds programmable exposure time, multi-row readout, continuous mode and abort.
//  Sits between the system controller and the PIXEL_ARRAY control/counter inputs.
// PARAMETERS
//  COUNTER_WIDTH    8   width of the shared conversion counter; CONVERT lasts 2**COUNTER_WIDTH cycles
//  NUM_ROWS         2   number of pixel rows read out per frame (>=1)
//  ERASE_CYCLES     5   cycles spent in ERASE (>=1)
//  EXPOSE_WIDTH     16  width of the EXPOSE_CYCLES input
//  READ_ROW_CYCLES  1   cycles READ_ROW is held per row (>=1)
// PORTS
//  SYSTEM_CLK     in   1               system clock, rising edge
//  RESET          in   1               asynchronous, active-high reset
//  START          in   1               frame request; sampled only in IDLE
//  ABORT          in   1               synchronous abort; has priority over all transitions
//  CONTINUOUS     in   1               1 = start the next frame automatically after DONE
//  EXPOSE_CYCLES  in   EXPOSE_WIDTH    exposure length; latched on frame start
//  ERASE          out  1               high in ERASE
//  EXPOSE         out  1               high in EXPOSE (gates VBN1 bias)
//  CONVERT        out  1               high in CONVERT (gates ANALOG_RAMP)
//  COUNTER_RESET  out  1               high in ERASE; clears the conversion counter
//  COUNTER_VALUE  out  COUNTER_WIDTH   conversion counter driven to the pixel memories
//  WRITE_ENABLE   out  1               1 = pixel memories track COUNTER_VALUE; 0 = hold
//  READ_ENABLE    out  1               high in READ
//  READ_ROW       out  max(1,$clog2(NUM_ROWS))  index of the row being driven on the data bus
//  BUSY           out  1               high in every state except IDLE
//  FRAME_DONE     out  1               one-cycle pulse in DONE
// BEHAVIOUR
//  Reset (async): state=IDLE, COUNTER_VALUE=0, READ_ROW=0, WRITE_ENABLE=1. All other outputs are 0.
//  All outputs are registered and are a decode of the current state and counters.
//  States: IDLE, ERASE, EXPOSE, CONVERT, READ, DONE. One internal phase counter.
//  IDLE:
//   - START=1 at an edge -> ERASE from the next cycle.
//   - EXPOSE_CYCLES is latched at the same edge. A latched value of 0 is treated as 1.
//  ERASE: ERASE_CYCLES cycles. COUNTER_RESET=1 and COUNTER_VALUE=0 -> EXPOSE.
//  EXPOSE: latched EXPOSE_CYCLES cycles -> CONVERT.
//  CONVERT:
//   - Lasts exactly 2**COUNTER_WIDTH cycles.
//   - COUNTER_VALUE = 0,1,...,2**COUNTER_WIDTH-1, one step per cycle. It never wraps.
//   - On leaving CONVERT, COUNTER_VALUE holds the maximum until the next ERASE.
//   - Next state is READ.
//  WRITE_ENABLE: 1 in IDLE/ERASE/EXPOSE/CONVERT; 0 in READ and DONE, so pixel values stay frozen.
//  READ:
//   - Lasts NUM_ROWS*READ_ROW_CYCLES cycles.
//   - READ_ROW starts at 0 and increments every READ_ROW_CYCLES cycles, ending at NUM_ROWS-1.
//   - Next state is DONE.
//  DONE:
//   - One cycle, FRAME_DONE=1. READ_ROW returns to 0.
//   - Next state: ERASE if CONTINUOUS=1 (EXPOSE_CYCLES re-latched at this edge), else IDLE.
//  Latency: START edge k -> ERASE high from k+1 -> FRAME_DONE high for the single cycle after edge
//   k+ERASE_CYCLES+EXP+2**COUNTER_WIDTH+NUM_ROWS*READ_ROW_CYCLES, where EXP = latched exposure.
//  START outside IDLE is ignored. START is not queued.
//  ABORT=1 in any non-IDLE state:
//   - IDLE from the next cycle. No FRAME_DONE pulse.
//   - COUNTER_VALUE and READ_ROW are forced to 0; WRITE_ENABLE=1.
//   - ABORT beats START and CONTINUOUS at the same edge.
//  RESET mid-frame: immediate return to the reset values. No FRAME_DONE pulse.
//  Changes to EXPOSE_CYCLES mid-frame have no effect on the current frame.
// TESTING (defaults, EXPOSE_CYCLES=10)
//  1 Reset then idle: no START -> BUSY=0, WRITE_ENABLE=1, all other outputs 0, indefinitely.
//  2 START pulse at edge k:
//    - ERASE high for 5 cycles, then EXPOSE for 10, then CONVERT for 256.
//    - COUNTER_VALUE steps 0..255; READ_ROW is 0 then 1.
//    - FRAME_DONE high only in the cycle after edge k+273; BUSY low afterwards.
//  3 EXPOSE_CYCLES=0 -> EXPOSE high exactly 1 cycle. Change EXPOSE_CYCLES mid-frame -> no effect.
//  4 CONTINUOUS=1 -> ERASE follows FRAME_DONE with no IDLE gap; START mid-frame is ignored.
//  5 ABORT during CONVERT at COUNTER_VALUE=100:
//    - IDLE next cycle, COUNTER_VALUE=0, no FRAME_DONE.
//    - A fresh START then completes normally.
//  6 RESET asserted during READ (READ_ROW=1) -> outputs take reset values asynchronously.

Source files
------------

// File: rtl/pixel_array_sequencer.sv
// Frame controller for the pixel array: erase -> expose -> convert -> row readout.
// Latency: START edge k -> FRAME_DONE after edge k+ERASE+EXP+2**CW+ROWS*RRC; no backpressure, START ignored while busy.
module pixel_array_sequencer #(
    parameter int COUNTER_WIDTH   = 8,
    parameter int NUM_ROWS        = 2,
    parameter int ERASE_CYCLES    = 5,
    parameter int EXPOSE_WIDTH    = 16,
    parameter int READ_ROW_CYCLES = 1
) (
    input  logic                     SYSTEM_CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic                     CONTINUOUS,
    input  logic [EXPOSE_WIDTH-1:0]  EXPOSE_CYCLES,
    output logic                     ERASE,
    output logic                     EXPOSE,
    output logic                     CONVERT,
    output logic                     COUNTER_RESET,
    output logic [COUNTER_WIDTH-1:0] COUNTER_VALUE,
    output logic                     WRITE_ENABLE,
    output logic                     READ_ENABLE,
    output logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0] READ_ROW,
    output logic                     BUSY,
    output logic                     FRAME_DONE
);

    localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int ERASE_W  = $clog2(ERASE_CYCLES + 1);
    localparam int RRC_W    = $clog2(READ_ROW_CYCLES + 1);
    localparam int PHASE_W0 = (ERASE_W > EXPOSE_WIDTH) ? ERASE_W : EXPOSE_WIDTH;
    localparam int PHASE_W  = (RRC_W > PHASE_W0) ? RRC_W : PHASE_W0;

    localparam logic [PHASE_W-1:0] ERASE_LAST = PHASE_W'(ERASE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RRC_LAST   = PHASE_W'(READ_ROW_CYCLES - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic [EXPOSE_WIDTH-1:0]  exp_q, exp_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0]         row_q, row_d;

    logic erase_q, erase_d;
    logic expose_q, expose_d;
    logic convert_q, convert_d;
    logic write_enable_q, write_enable_d;
    logic read_enable_q, read_enable_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;

    logic [EXPOSE_WIDTH-1:0] exp_in;
    logic [EXPOSE_WIDTH-1:0] exp_last;

    // A zero exposure request still gets one EXPOSE cycle.
    assign exp_in   = (EXPOSE_CYCLES == '0) ? EXPOSE_WIDTH'(1) : EXPOSE_CYCLES;
    assign exp_last = exp_q - EXPOSE_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_ERASE;
                    phase_d = '0;
                    exp_d   = exp_in;
                    cnt_d   = '0;
                end
            end
            S_ERASE: begin
                cnt_d = '0;
                if (phase_q == ERASE_LAST) begin
                    state_d = S_EXPOSE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            S_EXPOSE: begin
                if (phase_q == PHASE_W'(exp_last)) begin
                    state_d = S_CONVERT;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            S_CONVERT: begin
                // Counter saturates at its maximum; that value is what the pixels hold.
                if (cnt_q == '1) begin
                    state_d = S_READ;
                    phase_d = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + COUNTER_WIDTH'(1);
                end
            end
            S_READ: begin
                if (phase_q == RRC_LAST) begin
                    phase_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = S_DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            S_DONE: begin
                if (CONTINUOUS) begin
                    state_d = S_ERASE;
                    phase_d = '0;
                    exp_d   = exp_in;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition, including a START seen in IDLE.
        if (ABORT) begin
            state_d = S_IDLE;
            phase_d = '0;
            exp_d   = exp_q;
            if (state_q != S_IDLE) begin
                cnt_d = '0;
                row_d = '0;
            end
        end

        erase_d        = (state_d == S_ERASE);
        expose_d       = (state_d == S_EXPOSE);
        convert_d      = (state_d == S_CONVERT);
        read_enable_d  = (state_d == S_READ);
        frame_done_d   = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
        write_enable_d = !((state_d == S_READ) || (state_d == S_DONE));
    end

    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            exp_q          <= '0;
            cnt_q          <= '0;
            row_q          <= '0;
            erase_q        <= 1'b0;
            expose_q       <= 1'b0;
            convert_q      <= 1'b0;
            write_enable_q <= 1'b1;
            read_enable_q  <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            exp_q          <= exp_d;
            cnt_q          <= cnt_d;
            row_q          <= row_d;
            erase_q        <= erase_d;
            expose_q       <= expose_d;
            convert_q      <= convert_d;
            write_enable_q <= write_enable_d;
            read_enable_q  <= read_enable_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign ERASE         = erase_q;
    assign COUNTER_RESET = erase_q;
    assign EXPOSE        = expose_q;
    assign CONVERT       = convert_q;
    assign COUNTER_VALUE = cnt_q;
    assign WRITE_ENABLE  = write_enable_q;
    assign READ_ENABLE   = read_enable_q;
    assign READ_ROW      = row_q;
    assign BUSY          = busy_q;
    assign FRAME_DONE    = frame_done_q;

endmodule
